mem_responder: RTL and testbench

Word-organised memory target that answers the CPU's address/data bus, acting as the responder side of the CPU's fetch, load and store traffic. It accepts one request at a time through a req/ack handshake and inserts a configurable number of wait states. It decodes the address against a base window and returns read data or commits byte-enabled writes. Out-of-window or misaligned accesses complete with an error flag instead of hanging the CPU.

---
 rtl/mem_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-organised memory target that answers the CPU's address/data bus.
// One request is taken at a time. Each request waits WAIT_STATES cycles and
// then completes with a single-cycle ack. An out-of-window or misaligned
// access completes with o_err set instead of touching memory.
//
// Handshake: a request is accepted on a rising edge where the block is IDLE
// and i_req=1. i_we/i_addr/i_wdata/i_be are captured on that same edge.
// o_ack pulses for exactly one cycle per accepted request, and o_err
// qualifies that pulse. i_req is ignored while the block is busy, so a
// request held high is taken again on the first IDLE cycle after the ack.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-low reset
//   i_req    request strobe
//   i_we     1 = write, 0 = read
//   i_addr   byte address
//   i_wdata  write data
//   i_be     byte enables, bit n selects bits [8n+7:8n]
//   o_data   read data (ERR_DATA on an errored read), held between reads
//   o_ack    single-cycle completion pulse
//   o_err    1 = access rejected, only ever high together with o_ack
//   o_busy   high from the cycle after acceptance through the ack cycle
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'hb0000000,
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ERR_DATA    = 32'hdeadbeef
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_be,
   output logic [31:0] o_data,
   output logic        o_ack,
   output logic        o_err,
   output logic        o_busy
);

   localparam int          DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [31:0] SPAN      = 32'd4 << DEPTH_LOG2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic                    err_q, err_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              be_q, be_d;
   logic                    ack_q, ack_d;
   logic                    rsp_err_q, rsp_err_d;
   logic                    busy_q, busy_d;
   logic                    data_err_q, data_err_d;
   logic [31:0]             rd_q;

   // Address decode of the incoming request. Addresses below ADDR_BASE wrap
   // to a huge offset and fall out of range naturally.
   logic [31:0]             in_offset;
   logic                    in_err;
   logic [DEPTH_LOG2-1:0]   in_idx;

   // The transaction that completes this cycle. With no wait states it is
   // the one being accepted right now, so it comes straight off the inputs.
   logic                    go_resp;
   logic                    cur_we;
   logic                    cur_err;
   logic [DEPTH_LOG2-1:0]   cur_idx;
   logic [31:0]             cur_wdata;
   logic [3:0]              cur_be;
   logic                    mem_we;
   logic                    mem_rd;

   logic [31:0]             mem [DEPTH];

   always_comb begin
      in_offset = i_addr - ADDR_BASE;
      in_err    = (in_offset >= SPAN) || (i_addr[1:0] != 2'b00);
      in_idx    = in_offset[DEPTH_LOG2+1:2];
   end

   always_comb begin
      go_resp = ((state_q == ST_IDLE) && i_req && (WAIT_STATES == 0)) ||
                ((state_q == ST_WAIT) && (cnt_q == 4'd0));
      if (state_q == ST_IDLE) begin
         cur_we    = i_we;
         cur_err   = in_err;
         cur_idx   = in_idx;
         cur_wdata = i_wdata;
         cur_be    = i_be;
      end else begin
         cur_we    = we_q;
         cur_err   = err_q;
         cur_idx   = idx_q;
         cur_wdata = wdata_q;
         cur_be    = be_q;
      end
      // The write is gated by reset so that a reset landing on the commit
      // edge aborts the pending write.
      mem_we = go_resp && cur_we && !cur_err && reset;
      mem_rd = go_resp && !cur_we && !cur_err;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      err_d      = err_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      ack_d      = 1'b0;
      rsp_err_d  = 1'b0;
      busy_d     = busy_q;
      data_err_d = data_err_q;

      case (state_q)
         ST_IDLE: begin
            if (i_req) begin
               we_d    = i_we;
               err_d   = in_err;
               idx_d   = in_idx;
               wdata_d = i_wdata;
               be_d    = i_be;
               busy_d  = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d   = ST_RESPOND;
                  ack_d     = 1'b1;
                  rsp_err_d = in_err;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d   = ST_RESPOND;
               ack_d     = 1'b1;
               rsp_err_d = err_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // o_data switches between RAM output and ERR_DATA only on reads;
      // writes leave the previous read result on the bus.
      if (go_resp && !cur_we) begin
         data_err_d = cur_err;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= 4'd0;
         ack_q      <= 1'b0;
         rsp_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         data_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         err_q      <= err_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         ack_q      <= ack_d;
         rsp_err_q  <= rsp_err_d;
         busy_q     <= busy_d;
         data_err_q <= data_err_d;
      end
   end

   // Single-port synchronous RAM: one access per cycle on cur_idx, registered
   // read port with a synchronous reset on the output register only.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) begin
               mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
         end
      end
      if (!reset) begin
         rd_q <= '0;
      end else if (mem_rd) begin
         rd_q <= mem[cur_idx];
      end
   end

   assign o_data = data_err_q ? ERR_DATA : rd_q;
   assign o_ack  = ack_q;
   assign o_err  = rsp_err_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Four instances of mem_responder with WAIT_STATES = 0, 1, 3, 4 share clock
// and reset and have independent request buses. A behavioural model (byte
// merges into an associative array, 64-bit address window arithmetic)
// supplies every expected value.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int     N      = 4;
   localparam int     DEPTH  = 1024;
   localparam longint BASE_L = 64'h00000000_b0000000;
   localparam logic [31:0] BASE = 32'hb0000000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b0;

   logic        req   [N];
   logic        we    [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];
   logic [3:0]  be    [N];
   logic [31:0] data  [N];
   logic        ack   [N];
   logic        err   [N];
   logic        busy  [N];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_responder #(
         .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4)
      ) u_dut (
         .clk     (clk),
         .reset   (reset),
         .i_req   (req[g]),
         .i_we    (we[g]),
         .i_addr  (addr[g]),
         .i_wdata (wdata[g]),
         .i_be    (be[g]),
         .o_data  (data[g]),
         .o_ack   (ack[g]),
         .o_err   (err[g]),
         .o_busy  (busy[g])
      );
   end

   function automatic int ws_of(input int d);
      case (d)
         0:       return 0;
         1:       return 1;
         2:       return 3;
         default: return 4;
      endcase
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [int];
   logic [31:0] last_data  [N];
   bit          last_known [N];

   function automatic bit exp_err(input logic [31:0] a);
      longint ua;
      ua = longint'(a);
      return (ua < BASE_L) || (ua >= BASE_L + 4 * DEPTH) || (ua % 4 != 0);
   endfunction

   function automatic int key_of(input int d, input logic [31:0] a);
      return d * DEPTH + int'((longint'(a) - BASE_L) / 4);
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] b);
      logic [31:0] w;
      int k;
      if (exp_err(a)) return;
      k = key_of(d, a);
      if (ref_mem.exists(k)) begin
         w = ref_mem[k];
         for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
         ref_mem[k] = w;
      end else if (b == 4'hf) begin
         ref_mem[k] = wd;
      end
   endtask

   // Expected read result; known=0 when the word was never fully written.
   task automatic model_read(input int d, input logic [31:0] a,
                             output logic [31:0] v, output bit known);
      int k;
      v = '0;
      known = 1'b0;
      if (exp_err(a)) begin
         v = 32'hdeadbeef;
         known = 1'b1;
      end else begin
         k = key_of(d, a);
         if (ref_mem.exists(k)) begin
            v = ref_mem[k];
            known = 1'b1;
         end
      end
      last_data[d]  = v;
      last_known[d] = known;
   endtask

   task automatic model_reset();
      for (int d = 0; d < N; d++) begin
         last_data[d]  = '0;
         last_known[d] = 1'b1;
      end
   endtask

   // ---------------- driver ----------------
   // Issues one request on instance d and returns what the bus showed.
   // lat counts falling edges from acceptance to the ack (inclusive).
   task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output logic [31:0] rdata, output logic rerr,
                         output int lat, output int busy_cnt, output logic ack_after);
      @(negedge clk);
      req[d]   = 1'b1;
      we[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      be[d]    = b;
      @(negedge clk);
      // Scramble the bus so that only the captured values can matter.
      req[d]   = 1'b0;
      we[d]    = 1'($urandom_range(0, 1));
      addr[d]  = $urandom;
      wdata[d] = $urandom;
      be[d]    = 4'($urandom_range(0, 15));
      lat      = 1;
      busy_cnt = 0;
      while (!ack[d] && lat < 40) begin
         if (busy[d]) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (busy[d]) busy_cnt++;
      rdata = data[d];
      rerr  = err[d];
      @(negedge clk);
      ack_after = ack[d];
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         checks++;
         if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]); end
         checks++;
         if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
         checks++;
         if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
         checks++;
         if (data[d] !== 32'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 0", d, data[d]); end
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_read();
      logic [31:0] rd, ev;
      logic re, aa;
      int lat, bc;
      bit kn;
      do_txn(1, 1'b1, BASE, 32'h12345678, 4'hf, rd, re, lat, bc, aa);
      model_write(1, BASE, 32'h12345678, 4'hf);
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL preload_err: got %b expected 0", re); end
      checks++;
      if (rd !== last_data[1]) begin errors++; $display("FAIL write_holds_data: got %h expected %h", rd, last_data[1]); end
      do_txn(1, 1'b0, BASE, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, BASE, ev, kn);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
      checks++;
      if (rd !== ev) begin errors++; $display("FAIL read_data: got %h expected %h", rd, ev); end
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", re); end
      checks++;
      if (bc !== 2) begin errors++; $display("FAIL read_busy_cycles: got %0d expected 2", bc); end
      checks++;
      if (aa !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b expected 0", aa); end
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd, ev;
      logic re, aa;
      int lat, bc;
      bit kn;
      do_txn(1, 1'b1, BASE + 32'h4, 32'h11223344, 4'hf, rd, re, lat, bc, aa);
      model_write(1, BASE + 32'h4, 32'h11223344, 4'hf);
      do_txn(1, 1'b1, BASE + 32'h4, 32'hAABBCCDD, 4'b0101, rd, re, lat, bc, aa);
      model_write(1, BASE + 32'h4, 32'hAABBCCDD, 4'b0101);
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL be_write_err: got %b expected 0", re); end
      do_txn(1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, BASE + 32'h4, ev, kn);
      checks++;
      if (rd !== ev || ev !== 32'h11BB33DD) begin errors++; $display("FAIL be_readback: got %h expected %h", rd, 32'h11BB33DD); end
      // i_be = 0 is a no-op write that still acknowledges.
      do_txn(1, 1'b1, BASE + 32'h4, 32'hFFFFFFFF, 4'b0000, rd, re, lat, bc, aa);
      checks++;
      if (lat !== 2 || re !== 1'b0) begin errors++; $display("FAIL be_zero_ack: got lat=%0d err=%b expected lat=2 err=0", lat, re); end
      do_txn(1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, BASE + 32'h4, ev, kn);
      checks++;
      if (rd !== ev) begin errors++; $display("FAIL be_zero_readback: got %h expected %h", rd, ev); end
   endtask

   task automatic test_range();
      logic [31:0] rd, ev;
      logic re, aa;
      int lat, bc;
      bit kn;
      do_txn(1, 1'b0, 32'hb0000ffc, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, 32'hb0000ffc, ev, kn);
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL range_top_err: got %b expected 0", re); end
      do_txn(1, 1'b0, 32'hb0001000, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, 32'hb0001000, ev, kn);
      checks++;
      if (re !== 1'b1) begin errors++; $display("FAIL range_past_err: got %b expected 1", re); end
      checks++;
      if (rd !== ev) begin errors++; $display("FAIL range_past_data: got %h expected %h", rd, ev); end
      do_txn(1, 1'b0, 32'haffffffc, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, 32'haffffffc, ev, kn);
      checks++;
      if (re !== 1'b1) begin errors++; $display("FAIL range_below_err: got %b expected 1", re); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL range_err_latency: got %0d expected 2", lat); end
   endtask

   task automatic test_misaligned_write();
      logic [31:0] rd, ev, held;
      logic re, aa;
      int lat, bc;
      bit kn;
      held = last_data[1];
      do_txn(1, 1'b1, 32'hb0000002, 32'hCAFEF00D, 4'hf, rd, re, lat, bc, aa);
      model_write(1, 32'hb0000002, 32'hCAFEF00D, 4'hf);
      checks++;
      if (re !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b expected 1", re); end
      checks++;
      if (rd !== held) begin errors++; $display("FAIL misaligned_holds_data: got %h expected %h", rd, held); end
      do_txn(1, 1'b0, BASE, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(1, BASE, ev, kn);
      checks++;
      if (rd !== ev || ev !== 32'h12345678) begin errors++; $display("FAIL misaligned_untouched: got %h expected %h", rd, 32'h12345678); end
   endtask

   task automatic test_random();
      logic [31:0] rd, ev, a, wd;
      logic [3:0] b;
      logic re, aa, w;
      int lat, bc, d, sel;
      bit kn;
      for (int k = 0; k < 40; k++) begin
         d   = $urandom_range(0, N - 1);
         sel = $urandom_range(0, 7);
         case (sel)
            4:       a = BASE + 32'hffc;
            5:       a = BASE + 32'h1000 + 4 * $urandom_range(0, 3);
            6:       a = BASE - 4 * $urandom_range(1, 4);
            7:       a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            default: a = BASE + 4 * $urandom_range(0, 15);
         endcase
         w  = 1'($urandom_range(0, 1));
         b  = 4'($urandom_range(0, 15));
         wd = $urandom;
         ev = last_data[d];
         kn = last_known[d];
         do_txn(d, w, a, wd, b, rd, re, lat, bc, aa);
         if (w) model_write(d, a, wd, b);
         else   model_read(d, a, ev, kn);
         checks++;
         if (lat !== ws_of(d) + 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", d, lat, ws_of(d) + 1); end
         checks++;
         if (bc !== ws_of(d) + 1) begin errors++; $display("FAIL rnd_busy[%0d]: got %0d expected %0d", d, bc, ws_of(d) + 1); end
         checks++;
         if (re !== exp_err(a)) begin errors++; $display("FAIL rnd_err[%0d] addr %h: got %b expected %b", d, a, re, exp_err(a)); end
         checks++;
         if (aa !== 1'b0) begin errors++; $display("FAIL rnd_ack_pulse[%0d]: got %b expected 0", d, aa); end
         if (kn) begin
            checks++;
            if (rd !== ev) begin errors++; $display("FAIL rnd_data[%0d] addr %h: got %h expected %h", d, a, rd, ev); end
         end
      end
   endtask

   // i_req held high for 10 edges on a read: acks are predicted from the
   // rule "next acceptance no earlier than WAIT_STATES+2 cycles later".
   task automatic test_back_to_back(input int d);
      logic [31:0] exp_q[$];
      logic [31:0] obs_q[$];
      int free_t, prev;
      bit err_seen;
      free_t   = 1;
      err_seen = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         if (t >= free_t) begin
            exp_q.push_back(32'(t + ws_of(d)));
            free_t = t + ws_of(d) + 2;
         end
      end
      @(negedge clk);
      req[d]  = 1'b1;
      we[d]   = 1'b0;
      addr[d] = BASE + 32'h10;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (ack[d]) obs_q.push_back(32'(i));
         if (err[d]) err_seen = 1'b1;
         if (i == 10) req[d] = 1'b0;
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", d, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ack_cycle[%0d] #%0d: got %0d expected %0d", d, i, obs_q[i], exp_q[i]); end
      end
      prev = -10;
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (int'(obs_q[i]) - prev < 2) begin errors++; $display("FAIL b2b_consecutive[%0d]: got ack at %0d after %0d expected gap>=2", d, obs_q[i], prev); end
         prev = int'(obs_q[i]);
      end
      checks++;
      if (err_seen !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got 1 expected 0", d); end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd, ev;
      logic re, aa;
      int lat, bc, acks;
      bit kn;
      do_txn(3, 1'b1, BASE + 32'h20, 32'h0BADF00D, 4'hf, rd, re, lat, bc, aa);
      model_write(3, BASE + 32'h20, 32'h0BADF00D, 4'hf);
      @(negedge clk);
      req[3]   = 1'b1;
      we[3]    = 1'b1;
      addr[3]  = BASE + 32'h20;
      wdata[3] = 32'h55AA55AA;
      be[3]    = 4'hf;
      @(negedge clk);
      req[3] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      model_reset();
      checks++;
      if (ack[3] !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", ack[3]); end
      checks++;
      if (err[3] !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", err[3]); end
      checks++;
      if (busy[3] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy[3]); end
      checks++;
      if (data[3] !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", data[3]); end
      @(negedge clk);
      reset = 1'b1;
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (ack[3]) acks++;
      end
      checks++;
      if (acks !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks expected 0", acks); end
      do_txn(3, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, re, lat, bc, aa);
      model_read(3, BASE + 32'h20, ev, kn);
      checks++;
      if (rd !== ev) begin errors++; $display("FAIL midrst_word_unchanged: got %h expected %h", rd, ev); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      for (int d = 0; d < N; d++) begin
         req[d]   = 1'b0;
         we[d]    = 1'b0;
         addr[d]  = '0;
         wdata[d] = '0;
         be[d]    = '0;
      end
      test_reset();
      test_read();
      test_byte_enable();
      test_range();
      test_misaligned_write();
      test_random();
      test_back_to_back(0);
      test_back_to_back(2);
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
